// File: rtl/osd_diag_event_monitor.sv
// Multi-channel address watchpoint monitor: counts window matches, captures
// timestamped event records and streams them out as 4-flit packets.
module osd_diag_event_monitor #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic              mon_valid,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic              mon_we,
  input  logic [31:0]       timestamp,
  output logic [15:0]       out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       dropped_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic             ovf;
    logic [3:0]       ch;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ts;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_F3   = 3'd4
  } state_t;

  function automatic logic [ADDR_W-1:0] merge_half(input logic [ADDR_W-1:0] cur,
                                                   input logic [15:0] d,
                                                   input logic hi);
    logic [31:0] full;
    full = 32'(cur);
    if (hi) full[31:16] = d;
    else    full[15:0]  = d;
    return full[ADDR_W-1:0];
  endfunction

  function automatic logic [15:0] hdr_flit(input rec_t r);
    return {r.ovf, 11'b0, r.ch};
  endfunction

  logic              g_en_r;
  logic [NUM_CH-1:0] en_r;
  logic [1:0]        dir_r  [NUM_CH];
  logic [ADDR_W-1:0] base_r [NUM_CH];
  logic [ADDR_W-1:0] mask_r [NUM_CH];
  logic [CNT_W-1:0]  thr_r  [NUM_CH];
  logic [CNT_W-1:0]  cnt_r  [NUM_CH];
  rec_t              pend_r [NUM_CH];
  logic [NUM_CH-1:0] pend_v_r;

  logic [4:0]        cfg_ch_s;
  logic [2:0]        cfg_k_s;
  logic              glb_wr_s;
  logic [NUM_CH-1:0] ctrl_wr_s;
  logic [NUM_CH-1:0] dir_ok_s;
  logic [NUM_CH-1:0] match_s;
  logic [NUM_CH-1:0] trig_s;
  logic [CNT_W-1:0]  cnt_inc_s [NUM_CH];
  logic [CNT_W-1:0]  thr_eff_s [NUM_CH];
  logic [NUM_CH-1:0] deq_s;
  logic              enq_s;
  rec_t              sel_rec_s;

  rec_t              mem_r [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     fill_s;
  logic [AW-1:0]     rd_nxt_idx_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              hs_s;
  rec_t              head_s;
  rec_t              next_s;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [15:0]       out_data_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [15:0]       data_nxt_s;
  logic              valid_nxt_s;
  logic              last_nxt_s;
  logic [15:0]       dropped_r;

  assign cfg_ch_s = cfg_addr[7:3];
  assign cfg_k_s  = cfg_addr[2:0];
  assign glb_wr_s = cfg_we && (cfg_addr == 8'(NUM_CH * 8));

  // Configuration register file written by the register-access layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_en_r <= 1'b0;
      en_r   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        dir_r[c]  <= 2'b00;
        base_r[c] <= '0;
        mask_r[c] <= '0;
        thr_r[c]  <= '0;
      end
    end else begin
      if (glb_wr_s) begin
        g_en_r <= cfg_wdata[0];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && (cfg_ch_s == 5'(c))) begin
          case (cfg_k_s)
            3'd0: begin
              en_r[c]  <= cfg_wdata[0];
              dir_r[c] <= cfg_wdata[2:1];
            end
            3'd1:    base_r[c] <= merge_half(base_r[c], cfg_wdata, 1'b0);
            3'd2:    base_r[c] <= merge_half(base_r[c], cfg_wdata, 1'b1);
            3'd3:    mask_r[c] <= merge_half(mask_r[c], cfg_wdata, 1'b0);
            3'd4:    mask_r[c] <= merge_half(mask_r[c], cfg_wdata, 1'b1);
            3'd5:    thr_r[c]  <= cfg_wdata[CNT_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Per-channel match qualification and threshold detection.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_wr_s[c] = cfg_we && (cfg_ch_s == 5'(c)) && (cfg_k_s == 3'd0);
      case (dir_r[c])
        2'b00:   dir_ok_s[c] = 1'b1;
        2'b01:   dir_ok_s[c] = mon_we;
        2'b10:   dir_ok_s[c] = ~mon_we;
        default: dir_ok_s[c] = 1'b0;
      endcase
      match_s[c]   = mon_valid && g_en_r && en_r[c] && dir_ok_s[c] &&
                     ((mon_addr & mask_r[c]) == (base_r[c] & mask_r[c]));
      cnt_inc_s[c] = cnt_r[c] + CNT_W'(1);
      thr_eff_s[c] = (thr_r[c] == '0) ? CNT_W'(1) : thr_r[c];
      trig_s[c]    = match_s[c] && (cnt_inc_s[c] == thr_eff_s[c]);
    end
  end

  // Lowest-index pending record is offered to the FIFO each cycle.
  always_comb begin
    deq_s     = pend_v_r & (~pend_v_r + NUM_CH'(1));
    enq_s     = |pend_v_r;
    sel_rec_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_rec_s = deq_s[c] ? pend_r[c] : sel_rec_s;
    end
  end

  // Match counters and pending record registers; a ctrl write overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_r[c]  <= '0;
        pend_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ctrl_wr_s[c]) begin
          cnt_r[c]    <= '0;
          pend_v_r[c] <= 1'b0;
          pend_r[c]   <= '0;
        end else begin
          if (trig_s[c]) begin
            cnt_r[c] <= '0;
          end else if (match_s[c]) begin
            cnt_r[c] <= cnt_inc_s[c];
          end
          if (trig_s[c] && (!pend_v_r[c] || deq_s[c])) begin
            pend_v_r[c]   <= 1'b1;
            pend_r[c].ovf <= 1'b0;
            pend_r[c].ch  <= 4'(c);
            pend_r[c].cnt <= cnt_inc_s[c];
            pend_r[c].ts  <= timestamp;
          end else if (trig_s[c]) begin
            pend_r[c].ovf <= 1'b1;
          end else if (deq_s[c]) begin
            pend_v_r[c] <= 1'b0;
          end
        end
      end
    end
  end

  assign fill_s       = wr_ptr_r - rd_ptr_r;
  assign empty_s      = (wr_ptr_r == rd_ptr_r);
  assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign hs_s         = out_valid_r && out_ready;
  assign pop_s        = (state_r == S_F3) && hs_s;
  assign push_s       = enq_s && (!full_s || pop_s);
  assign drop_s       = enq_s && !push_s;
  assign rd_nxt_idx_s = rd_ptr_r[AW-1:0] + AW'(1);
  assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
  // A record pushed while the last one pops is forwarded straight to F0.
  assign next_s       = (fill_s > PW'(1)) ? mem_r[rd_nxt_idx_s] : sel_rec_s;

  // Record storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= sel_rec_s;
    end
  end

  // FIFO pointers and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      dropped_r <= 16'h0000;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      if (glb_wr_s && cfg_wdata[1]) begin
        dropped_r <= 16'h0000;
      end else if (drop_s && (dropped_r != 16'hFFFF)) begin
        dropped_r <= dropped_r + 16'd1;
      end
    end
  end

  // Serializer next-state and registered-output computation.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = out_data_r;
    valid_nxt_s = out_valid_r;
    last_nxt_s  = out_last_r;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          state_nxt_s = S_F0;
          data_nxt_s  = hdr_flit(head_s);
          valid_nxt_s = 1'b1;
          last_nxt_s  = 1'b0;
        end else begin
          data_nxt_s  = 16'h0000;
          valid_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
        end
      end
      S_F0: begin
        if (hs_s) begin
          state_nxt_s = S_F1;
          data_nxt_s  = 16'(head_s.cnt);
        end else begin
          state_nxt_s = S_F0;
        end
      end
      S_F1: begin
        if (hs_s) begin
          state_nxt_s = S_F2;
          data_nxt_s  = head_s.ts[15:0];
        end else begin
          state_nxt_s = S_F1;
        end
      end
      S_F2: begin
        if (hs_s) begin
          state_nxt_s = S_F3;
          data_nxt_s  = head_s.ts[31:16];
          last_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = S_F2;
        end
      end
      S_F3: begin
        if (hs_s && ((fill_s > PW'(1)) || push_s)) begin
          state_nxt_s = S_F0;
          data_nxt_s  = hdr_flit(next_s);
          valid_nxt_s = 1'b1;
          last_nxt_s  = 1'b0;
        end else if (hs_s) begin
          state_nxt_s = S_IDLE;
          data_nxt_s  = 16'h0000;
          valid_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = S_F3;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        data_nxt_s  = 16'h0000;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
      end
    endcase
  end

  // Serializer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      out_data_r  <= 16'h0000;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_data_r  <= data_nxt_s;
      out_valid_r <= valid_nxt_s;
      out_last_r  <= last_nxt_s;
    end
  end

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign dropped_cnt = dropped_r;

endmodule

// File: tb/tb_osd_diag_event_monitor.sv
// Directed bench for osd_diag_event_monitor: record-level reference model with
// a per-cycle output compare plus literal checks taken from the test plan.
module tb_osd_diag_event_monitor;
  localparam int NUM_CH     = 4;
  localparam int ADDR_W     = 32;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [7:0]        cfg_addr;
  logic [15:0]       cfg_wdata;
  logic              mon_valid;
  logic [ADDR_W-1:0] mon_addr;
  logic              mon_we;
  logic [31:0]       timestamp;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [15:0]       dropped_cnt;

  int errors = 0;
  int checks = 0;

  osd_diag_event_monitor #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .mon_valid(mon_valid), .mon_addr(mon_addr),
    .mon_we(mon_we), .timestamp(timestamp), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic        ovf;
    logic [3:0]  ch;
    logic [15:0] cnt;
    logic [31:0] ts;
  } mrec_t;

  mrec_t       mq[$];
  mrec_t       mpend [NUM_CH];
  bit          mpv   [NUM_CH];
  int          mcnt  [NUM_CH];
  bit          m_en  [NUM_CH];
  logic [1:0]  m_dir [NUM_CH];
  logic [31:0] m_base[NUM_CH];
  logic [31:0] m_mask[NUM_CH];
  int          m_thr [NUM_CH];
  bit          m_gen = 1'b0;
  int          mdrop = 0;
  bit          mv = 1'b0;
  int          fi = 0;

  function automatic bit mdir(input logic [1:0] d, input logic we);
    case (d)
      2'b00:   return 1'b1;
      2'b01:   return we;
      2'b10:   return !we;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] mflit(input mrec_t r, input int i);
    case (i)
      0:       return {r.ovf, 11'b0, r.ch};
      1:       return r.cnt;
      2:       return r.ts[15:0];
      default: return r.ts[31:16];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int    sel, thr, wc;
    bit    pop, was_ne, hit;
    mrec_t r;
    if (!rst_n) begin
      mq.delete();
      for (int c = 0; c < NUM_CH; c++) begin
        mpv[c] = 0; mcnt[c] = 0; m_en[c] = 0; m_dir[c] = 2'b00;
        m_base[c] = 32'h0; m_mask[c] = 32'h0; m_thr[c] = 0;
      end
      m_gen = 0; mdrop = 0; mv = 0; fi = 0;
    end else begin
      was_ne = mq.size() > 0;
      pop = mv && out_ready && (fi == 3);
      if (mv && out_ready && fi != 3) fi++;
      sel = -1;
      for (int c = NUM_CH - 1; c >= 0; c--) if (mpv[c]) sel = c;
      if (pop) void'(mq.pop_front());
      if (sel >= 0) begin
        mpv[sel] = 0;
        if (mq.size() < FIFO_DEPTH) mq.push_back(mpend[sel]);
        else if (mdrop < 65535) mdrop++;
      end
      if (pop) begin
        fi = 0;
        mv = mq.size() > 0;
      end else if (!mv && was_ne) begin
        mv = 1; fi = 0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        hit = mon_valid && m_gen && m_en[c] && mdir(m_dir[c], mon_we) &&
              (((mon_addr ^ m_base[c]) & m_mask[c]) == 32'h0);
        if (cfg_we && int'(cfg_addr) == c * 8) begin
          mcnt[c] = 0; mpv[c] = 0;
        end else if (hit) begin
          thr = (m_thr[c] == 0) ? 1 : m_thr[c];
          if (mcnt[c] + 1 == thr) begin
            mcnt[c] = 0;
            if (mpv[c]) mpend[c].ovf = 1'b1;
            else begin
              r.ovf = 1'b0; r.ch = 4'(c); r.cnt = 16'(thr); r.ts = timestamp;
              mpend[c] = r; mpv[c] = 1;
            end
          end else mcnt[c] = (mcnt[c] + 1) % 65536;
        end
      end
      if (cfg_we) begin
        if (int'(cfg_addr) == NUM_CH * 8) begin
          m_gen = cfg_wdata[0];
          if (cfg_wdata[1]) mdrop = 0;
        end else if (int'(cfg_addr) < NUM_CH * 8) begin
          wc = int'(cfg_addr) / 8;
          case (int'(cfg_addr) % 8)
            0: begin m_en[wc] = cfg_wdata[0]; m_dir[wc] = cfg_wdata[2:1]; end
            1: m_base[wc][15:0]  = cfg_wdata;
            2: m_base[wc][31:16] = cfg_wdata;
            3: m_mask[wc][15:0]  = cfg_wdata;
            4: m_mask[wc][31:16] = cfg_wdata;
            5: m_thr[wc] = int'(cfg_wdata);
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare and flit log ----------------
  logic [16:0] got[$];
  logic        prev_v = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b0;
  logic [15:0] prev_d = 16'h0;

  always @(negedge clk) begin
    checks++;
    if (out_valid !== mv) begin
      errors++;
      $display("FAIL model_valid: got %b expected %b at %0t", out_valid, mv, $time);
    end
    checks++;
    if (dropped_cnt !== 16'(mdrop)) begin
      errors++;
      $display("FAIL model_dropped: got %0d expected %0d at %0t", dropped_cnt, mdrop, $time);
    end
    if (mv && mq.size() > 0) begin
      checks++;
      if (out_data !== mflit(mq[0], fi) || out_last !== (fi == 3)) begin
        errors++;
        $display("FAIL model_flit: got %h/%b expected %h/%b at %0t",
                 out_data, out_last, mflit(mq[0], fi), (fi == 3), $time);
      end
    end
    if (prev_v && !prev_rdy && prev_rst && rst_n) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_d) begin
        errors++;
        $display("FAIL stall_hold: got %b/%h expected 1/%h at %0t", out_valid, out_data, prev_d, $time);
      end
    end
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    prev_v = out_valid; prev_rdy = out_ready; prev_d = out_data; prev_rst = rst_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] gf(input int i);
    if (i < got.size()) return got[i];
    else return 17'h1FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    timestamp = timestamp + 32'd1;
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic acc(input logic [31:0] a, input logic we);
    mon_valid = 1'b1; mon_addr = a; mon_we = we;
    step();
    mon_valid = 1'b0;
  endtask

  task automatic cfg_ch(input int c, input logic [31:0] base, input logic [31:0] mask,
                        input logic [15:0] thr, input logic [15:0] ctrl);
    cfg_wr(8'(c * 8 + 1), base[15:0]);
    cfg_wr(8'(c * 8 + 2), base[31:16]);
    cfg_wr(8'(c * 8 + 3), mask[15:0]);
    cfg_wr(8'(c * 8 + 4), mask[31:16]);
    cfg_wr(8'(c * 8 + 5), thr);
    cfg_wr(8'(c * 8),     ctrl);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 8'h0; cfg_wdata = 16'h0;
    mon_valid = 1'b0; mon_addr = 32'h0; mon_we = 1'b0; timestamp = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_last", 32'(out_last), 32'h0);
    chk("rst_dropped", 32'(dropped_cnt), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // single window, threshold 1, latency and flit contents
    cfg_ch(0, 32'h0000_1000, 32'hFFFF_FF00, 16'd1, 16'h0001);
    cfg_wr(8'(NUM_CH * 8), 16'h0001);
    got.delete();
    timestamp = 32'h0001_2345;
    acc(32'h0000_10A4, 1'b1);
    chk("t1_valid_c1", 32'(out_valid), 32'h0);
    step();
    chk("t1_valid_c2", 32'(out_valid), 32'h0);
    step();
    chk("t1_valid_c3", 32'(out_valid), 32'h1);
    chk("t1_data_c3", 32'(out_data), 32'h0000);
    repeat (8) step();
    chk("t1_nflits", 32'(got.size()), 32'd4);
    chk("t1_f0", 32'(gf(0)), 32'h00000);
    chk("t1_f1", 32'(gf(1)), 32'h00001);
    chk("t1_f2", 32'(gf(2)), 32'h02345);
    chk("t1_f3", 32'(gf(3)), 32'h10001);

    // reads-only channel, threshold 3, mixed reads and writes
    cfg_ch(1, 32'h0000_2000, 32'hFFFF_FF00, 16'd3, 16'h0005);
    got.delete();
    acc(32'h0000_2004, 1'b0);
    acc(32'h0000_2008, 1'b1);
    acc(32'h0000_2010, 1'b0);
    acc(32'h0000_2014, 1'b1);
    timestamp = 32'h0000_BEEF;
    acc(32'h0000_2018, 1'b0);
    repeat (10) step();
    chk("t2_nflits", 32'(got.size()), 32'd4);
    chk("t2_f0", 32'(gf(0)), 32'h00001);
    chk("t2_f1", 32'(gf(1)), 32'h00003);
    chk("t2_f2", 32'(gf(2)), 32'h0BEEF);
    chk("t2_f3", 32'(gf(3)), 32'h10000);

    // ch0 and ch2 (threshold 0 acts as 1) trigger together
    cfg_ch(2, 32'h0000_1000, 32'hFFFF_FF00, 16'd0, 16'h0001);
    got.delete();
    timestamp = 32'h00C0_FFEE;
    acc(32'h0000_1010, 1'b1);
    repeat (14) step();
    chk("t3_nflits", 32'(got.size()), 32'd8);
    chk("t3_r0_f0", 32'(gf(0)), 32'h00000);
    chk("t3_r0_f2", 32'(gf(2)), 32'h0FFEE);
    chk("t3_r0_f3", 32'(gf(3)), 32'h100C0);
    chk("t3_r1_f0", 32'(gf(4)), 32'h00002);
    chk("t3_r1_f1", 32'(gf(5)), 32'h00001);
    chk("t3_r1_f2", 32'(gf(6)), 32'h0FFEE);
    chk("t3_r1_f3", 32'(gf(7)), 32'h100C0);

    // overflow: 10 triggers with out_ready low
    cfg_wr(8'h00, 16'h0000);
    out_ready = 1'b0;
    got.delete();
    timestamp = 32'h0005_0000;
    for (int i = 0; i < 10; i++) begin
      acc(32'h0000_1020, 1'b0);
      step();
    end
    repeat (4) step();
    chk("t4_dropped", 32'(dropped_cnt), 32'd2);
    chk("t4_valid_stall", 32'(out_valid), 32'h1);
    chk("t4_data_stall", 32'(out_data), 32'h0002);
    chk("t4_none_sent", 32'(got.size()), 32'd0);
    chk("t4_fifo_full", 32'(dut.full_s), 32'h1);
    out_ready = 1'b1;
    repeat (40) step();
    chk("t4_nflits", 32'(got.size()), 32'd32);
    chk("t4_first_ts", 32'(gf(2)), 32'h00000);
    chk("t4_ts_span", 32'(16'(gf(30) - gf(2))), 32'd14);
    chk("t4_last_f0", 32'(gf(28)), 32'h00002);
    chk("t4_dropped_hold", 32'(dropped_cnt), 32'd2);
    cfg_wr(8'(NUM_CH * 8), 16'h0003);
    chk("t4_drop_clear", 32'(dropped_cnt), 32'd0);

    // toggling back-pressure
    got.delete();
    timestamp = 32'h0006_0000;
    for (int i = 0; i < 40; i++) begin
      mon_valid = (i < 3); mon_addr = 32'h0000_1030; mon_we = 1'b1;
      out_ready = i[0];
      step();
    end
    mon_valid = 1'b0;
    out_ready = 1'b1;
    chk("t5_nflits", 32'(got.size()), 32'd12);
    chk("t5_r0_f0", 32'(gf(0)), 32'h00002);
    chk("t5_r1_f0", 32'(gf(4)), 32'h00002);
    chk("t5_r2_f0", 32'(gf(8)), 32'h00002);
    chk("t5_r0_f3", 32'(gf(3)), 32'h10006);
    chk("t5_ts_step1", 32'(16'(gf(6) - gf(2))), 32'd1);
    chk("t5_ts_step2", 32'(16'(gf(10) - gf(6))), 32'd1);

    // reset in the middle of a packet
    timestamp = 32'hABCD_1234;
    acc(32'h0000_1040, 1'b0);
    step();
    step();
    chk("t6_f0", 32'(out_data), 32'h0002);
    step();
    chk("t6_f1", 32'(out_data), 32'h0001);
    step();
    chk("t6_f2", 32'(out_data), 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_data", 32'(out_data), 32'h0);
    chk("t6_rst_last", 32'(out_last), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    got.delete();
    step();
    acc(32'h0000_1040, 1'b0);
    repeat (12) step();
    chk("t6_no_residual", 32'(got.size()), 32'd0);
    chk("t6_dropped", 32'(dropped_cnt), 32'd0);
    chk("t6_idle", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osd_diag_event_monitor.md
# osd_diag_event_monitor

Parametrised, multi-channel address-watchpoint event monitor for the system-diagnosis debug path.
- Compares a memory-access stream against NUM_CH programmable base/mask windows.
- Counts matches per channel and, on reaching a programmable threshold, captures a timestamped event record.
- Buffers records in a FIFO and streams each as a 4-flit, 16-bit packet toward the debug-interconnect packetiser.
- Sits between the core/SRAM observation taps and the module's register-access layer; it generalises the single-window diagnosis datapath to N channels with thresholds, direction filters and overflow accounting.

## Interface
- NUM_CH, 4: number of watch channels, 1..16.
- ADDR_W, 32: monitored address width, 1..32.
- CNT_W, 16: match counter and threshold width, 1..16.
- FIFO_DEPTH, 8: event-record FIFO depth, a power of 2, at least 2.

- clk  in  1  module clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe from the register-access layer.
- cfg_addr  in  8  config register index.
- cfg_wdata  in  16  config write data.
- mon_valid  in  1  access observed this cycle.
- mon_addr  in  ADDR_W  access address.
- mon_we  in  1  1 = write access, 0 = read access.
- timestamp  in  32  free-running global timestamp.
- out_data  out  16  event flit.
- out_valid  out  1  flit valid.
- out_last  out  1  final flit of a record.
- out_ready  in  1  downstream accepts flit.
- dropped_cnt  out  16  saturating count of records lost to FIFO full.

## Operation
- Config map, channel c, register index c*8+k:
  - k=0: ctrl. Bit0 = enable; bits[2:1] = direction filter: 00 any, 01 writes only, 10 reads only, 11 never.
  - k=1/2: base address low/high 16 bits.
  - k=3/4: mask low/high 16 bits.
  - k=5: threshold.
  - Index NUM_CH*8: global ctrl, bit0 = global enable; bit1 written as 1 clears dropped_cnt (self-clearing).
  - Bits above ADDR_W and CNT_W are ignored. Writes to unmapped indices are ignored.
- Config writes take effect from the cycle after cfg_we. Writing a channel's ctrl register clears that channel's counter and pending record.
- Match for channel c requires all of:
  - mon_valid;
  - global enable and channel enable;
  - the direction filter passes;
  - (mon_addr & mask) == (base & mask).
- Counter: on each match, cnt+1 is compared with the effective threshold; threshold 0 is treated as 1.
  - If equal: trigger, and cnt returns to 0.
  - Otherwise cnt increments.
- Trigger: loads the channel's pending register with {ovf=0, count=cnt+1, ts=timestamp of the match cycle}. If pending is already full, the existing pending record is kept and its ovf bit is set.
- Enqueue: one pending record per cycle moves into the FIFO, lowest channel index first.
  - If the FIFO is full, the record is discarded, dropped_cnt increments (saturating at 16'hFFFF), and the pending register clears.
- Serializer FSM, states IDLE, F0, F1, F2, F3:
  - IDLE goes to F0 when the FIFO is non-empty.
  - Each state Fn advances only on out_valid & out_ready.
  - F3 pops the FIFO, then goes to F0 if the FIFO is still non-empty, else to IDLE.
- Flit contents:
  - F0: {ovf, 11'b0, 4-bit channel index}.
  - F1: count zero-extended to 16 bits.
  - F2: ts[15:0].
  - F3: ts[31:16], with out_last=1.

## Timing
- Reset (async assert, sync-safe deassert) clears:
  - all config registers, counters, pending registers and FIFO pointers;
  - dropped_cnt=0, FSM=IDLE;
  - out_valid=0, out_last=0, out_data=0.
- These outputs fall immediately on rst_n low, including mid-packet. A partially sent record is lost.
- Latency: mon_valid in cycle 0 gives pending set at edge 1, FIFO write at edge 2, and out_valid=1 with F0 in cycle 3.
- Throughput: one record per 4 cycles when out_ready is held high. There are no idle cycles between back-to-back records.
- Valid/ready: out_data, out_last and out_valid are registered. While out_valid=1 and out_ready=0 they hold stable. out_valid never drops without a handshake, except on reset.
- Simultaneous events:
  - Several channels trigger in one cycle: each loads its own pending register, and they drain one per cycle in index order.
  - A cfg ctrl write and a match on the same channel in the same cycle: the write wins, leaving counter 0 and pending empty.
  - A FIFO pop and push in the same cycle while full: the push succeeds.
- The FIFO uses a log2(FIFO_DEPTH)+1-bit pointer scheme. Full and empty are exact, with no lost slot.

## Test plan
- Ch0 base=0x1000, mask=0xFFFFFF00, threshold=1, enabled, global enabled; write to 0x10A4 at ts=0x00012345 -> flits 0x0000, 0x0001, 0x2345, 0x0001 (last); out_valid rises in cycle 3.
- Ch1 threshold=3, reads only; 3 reads and 2 writes into the window -> exactly one record after the 3rd read: F0=0x0001, F1=0x0003.
- Ch0 and ch2 trigger in the same cycle -> ch0 record emitted before ch2; both timestamps equal.
- out_ready held 0, FIFO_DEPTH=8, 10 triggers spaced 2 cycles apart -> the first 8 records are buffered, dropped_cnt=2, and the FIFO stays full until out_ready rises.
- Back-pressure: toggle out_ready every cycle -> out_data and out_valid stay stable while stalled; every 4-flit record is delivered intact and in order.
- Assert rst_n low during F2 -> out_valid=0 at once; after release, no residual flits are emitted and dropped_cnt=0.
